// File: rtl/srl_fifo_param_if.sv
// srl_fifo_param_if -- handshake/data bundle for srl_fifo_param.
//
// Signals:
//   wr, rd, din          producer/consumer requests and write data
//   dout                 oldest stored word (combinational read)
//   empty, full          fill-level extremes
//   almost_empty/full    programmable threshold flags
//   count                fill level, 0..DEPTH (AW+1 bits)
//   overflow, underflow  sticky rejected-request flags
//
// Modports:
//   master  the side issuing wr/rd (producer/consumer logic, testbench)
//   slave   the FIFO itself
interface srl_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, rd, din,
        input  dout, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  wr, rd, din,
        output dout, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/srl_fifo_param.sv
// srl_fifo_param -- parametrised shift-register FIFO, first-word-fall-through.
//
// New words enter at entry 0 and everything shifts up; the oldest word lives
// at entry count-1 and is read through a DEPTH:1 mux straight onto dout.
// The storage has no reset so it can map onto SRL primitives.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset (clears count and flags, not storage)
//   bus   srl_fifo_param_if.slave (wr/rd/din in; dout/status/count out)
//
// Parameters: WIDTH (1..64), DEPTH (power of two, 2..256),
//   AF_THRESH (1..DEPTH), AE_THRESH (0..DEPTH-1).
//
// Build option: define SRLQ_ERRFLAG_EN to build the sticky overflow and
// underflow flags; otherwise both outputs are tied to 0.
module srl_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic           clk,
    input  logic           rst,
    srl_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Thresholds narrowed to the count width so the compares are same-width.
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_C    = AE_THRESH[AW:0];

    generate
        if (WIDTH < 1 || WIDTH > 64)
            $error("srl_fifo_param: WIDTH %0d outside 1..64", WIDTH);
        if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0)
            $error("srl_fifo_param: DEPTH %0d must be a power of two in 2..256", DEPTH);
        if (AF_THRESH < 1 || AF_THRESH > DEPTH)
            $error("srl_fifo_param: AF_THRESH %0d outside 1..DEPTH", AF_THRESH);
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1)
            $error("srl_fifo_param: AE_THRESH %0d outside 0..DEPTH-1", AE_THRESH);
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt_q;
    logic [AW-1:0]    rd_addr;
    logic             empty_d;
    logic             full_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_d = (cnt_q == '0);
    assign full_d  = (cnt_q == DEPTH_C);

    // A write into a full FIFO is allowed when a read frees the slot on the
    // same edge; a read from empty is never allowed, even with a write.
    assign wr_ok = bus.wr & (~full_d | bus.rd);
    assign rd_ok = bus.rd & ~empty_d;

    // Shift-in storage, no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = DEPTH - 1; i > 0; i--)
                mem[i] <= mem[i-1];
            mem[0] <= bus.din;
        end
    end

    // When count == DEPTH the low AW bits are 0 and count-1 wraps to DEPTH-1,
    // which is exactly the oldest entry, so the MSB can be dropped here.
    assign rd_addr  = cnt_q[AW-1:0] - AW'(1);
    assign bus.dout = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (wr_ok & ~rd_ok)
            cnt_q <= cnt_q + (AW+1)'(1);
        else if (rd_ok & ~wr_ok)
            cnt_q <= cnt_q - (AW+1)'(1);
    end

    assign bus.count        = cnt_q;
    assign bus.empty        = empty_d;
    assign bus.full         = full_d;
    assign bus.almost_empty = (cnt_q <= AE_C);
    assign bus.almost_full  = (cnt_q >= AF_C);

`ifdef SRLQ_ERRFLAG_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.wr & ~wr_ok);
            udf_q <= udf_q | (bus.rd & ~rd_ok);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo_param.sv
// tb_srl_fifo_param -- self-checking bench for srl_fifo_param (WIDTH=8,
// DEPTH=16, AF=14, AE=1). A queue-based reference model tracks contents,
// fill level and sticky error flags; every cycle all outputs are compared.
module tb_srl_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    srl_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    srl_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count",        32'(bus.count),        32'(sz));
        chk("empty",        32'(bus.empty),        32'(sz == 0));
        chk("full",         32'(bus.full),         32'(sz == DEPTH));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
        chk("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
`ifdef SRLQ_ERRFLAG_EN
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_udf));
`else
        chk("overflow",     32'(bus.overflow),     32'(0));
        chk("underflow",    32'(bus.underflow),    32'(0));
`endif
        if (sz > 0)
            chk("dout", 32'(bus.dout), 32'(q[0]));
    endtask

    // One clock: drive, take the edge, advance the model, check #1 later.
    task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d);
        bit w_ok, r_ok;
        bus.wr  = w;
        bus.rd  = r;
        bus.din = d;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            w_ok = w && (q.size() < DEPTH || r);
            r_ok = r && (q.size() > 0);
            if (w && !w_ok) m_ovf = 1'b1;
            if (r && !r_ok) m_udf = 1'b1;
            if (r_ok) void'(q.pop_front());
            if (w_ok) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = '0;

        // Reset values
        #2;
        rst = 1'b1;
        cycle(0, 0, 8'h00);
        chk("rst_count", 32'(bus.count), 32'(0));
        chk("rst_empty", 32'(bus.empty), 32'(1));
        rst = 1'b0;

        // Fill with 0x01..0x10, no reads
        for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 8'(i));
        chk("fill_full", 32'(bus.full), 32'(1));
        chk("fill_dout", 32'(bus.dout), 32'h01);

        // Drain 16 words; model checks dout order 0x01..0x10
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);
        chk("drain_empty", 32'(bus.empty), 32'(1));

        // Full, simultaneous wr & rd for 50 cycles
        for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 8'(i));
        for (int i = 0; i < 50; i++) cycle(1, 1, 8'(8'h11 + i));
        chk("wrrd_full_count", 32'(bus.count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);

        // Empty, wr & rd with 0xA5: write accepted, read rejected
        cycle(1, 1, 8'hA5);
        chk("wrrd_empty_count", 32'(bus.count), 32'(1));
        chk("wrrd_empty_dout",  32'(bus.dout),  32'hA5);
        cycle(0, 1, 8'h00);

        // Extra write while full, then lone read while empty
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'(8'h40 + i));
        cycle(1, 0, 8'hEE);
        chk("ovf_dout", 32'(bus.dout), 32'h40);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00);
        cycle(0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00);   // flags stay sticky

        // Reset with a write pending at count=9
        rst = 1'b1;
        cycle(0, 0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) cycle(1, 0, 8'(8'h70 + i));
        rst = 1'b1;
        cycle(1, 0, 8'h99);
        rst = 1'b0;
        chk("midrst_count", 32'(bus.count), 32'(0));
        cycle(1, 0, 8'h3C);
        chk("post_rst_dout", 32'(bus.dout), 32'h3C);

        // Randomised traffic with shifting write/read bias
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                bit w, r;
                w = ($urandom_range(0, 99) < (ph[0] ? 70 : 35));
                r = ($urandom_range(0, 99) < (ph[0] ? 35 : 70));
                d = 8'($urandom);
                cycle(w, r, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/srl_fifo_param.md
# srl_fifo_param

Parametrised shift-register FIFO, the width/depth-generalised successor of the team's 8x16 SRL FIFO. It buffers WIDTH-bit words between a producer and a consumer in the same clock domain. Storage is a reset-less shift register that maps onto SRL primitives, with first-word-fall-through asynchronous read. It adds a fill-level output, programmable almost-full and almost-empty flags, and overflow/underflow protection. It sits on byte and word streams between the UART/ingress logic and the processing cores.

## Interface
- WIDTH, 8: data word width in bits, 1..64.
- DEPTH, 16: number of storage entries; power of two, 2..256. AW = clog2(DEPTH).
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr  in  1  write request; din is sampled on the same edge.
- rd  in  1  read request; dout is consumed on the same edge.
- din  in  WIDTH  write data.
- dout  out  WIDTH  oldest stored word (asynchronous read).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  AW+1  current fill level, 0..DEPTH.
- overflow  out  1  sticky flag: a write was rejected (SRLQ_ERRFLAG_EN only).
- underflow  out  1  sticky flag: a read was rejected (SRLQ_ERRFLAG_EN only).

## Operation
- Accept rules:
  - wr_ok = wr & (~full | rd).
  - rd_ok = rd & ~empty.
  - Rejected requests have no effect on storage or count.
- Storage:
  - On wr_ok, all entries shift up by one and entry 0 takes din.
  - Storage has no reset; its contents are undefined after power-up.
- Read address: count-1. The oldest word appears on dout combinationally while count > 0.
  - dout is don't-care while empty; the bench must not check it.
- Count update:
  - +1 when wr_ok & ~rd_ok.
  - -1 when rd_ok & ~wr_ok.
  - Unchanged otherwise. It never leaves the range 0..DEPTH.
- Status decode: empty, full, almost_empty and almost_full are decoded from the count register only, never from wr or rd.
- Boundary conditions:
  - Empty, wr & rd: the write is accepted and the read is rejected; count goes to 1. Underflow is flagged if SRLQ_ERRFLAG_EN is defined.
  - Full, wr & rd: both are accepted. The current oldest word is read, the shift discards it, and count stays at DEPTH.
  - Full, wr only: the write is rejected and the contents are unchanged.
  - Empty, rd only: the read is rejected and count stays at 0.
- Parameter checks: an illegal DEPTH, AF_THRESH or AE_THRESH must be caught at elaboration. Use a generate-time $error or an equivalent mechanism.

## Timing
- Write-to-read latency:
  - A word written at edge N is visible on dout after edge N once the FIFO was empty. The read can complete at edge N+1.
  - Fall-through is zero-cycle; there is no output register.
- count and all flags change only on the rising edge of clk. They reflect the state after that edge's accepted operations.
- Reset values (on the edge with rst=1): count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Reset mid-operation: rst has priority over wr and rd on the same edge. Storage is not cleared, but it is logically discarded because count returns to 0.
- Critical path: from the count register through the DEPTH:1 read mux to dout. This must meet timing for DEPTH=256 and WIDTH=32.

## Configuration
- SRLQ_ERRFLAG_EN:
  - Defined:
    - overflow sets on any edge with wr & ~wr_ok.
    - underflow sets on any edge with rd & ~rd_ok.
    - Both flags stay set until rst.
  - Undefined: overflow and underflow are tied to 0 and no flag registers are built. Accept rules are identical in both builds.

## Test plan
- Reset, then write 0x01..0x10 with DEPTH=16 and no reads -> count ramps 1..16 and full=1 after the 16th edge. almost_full=1 from count=14. dout=0x01 throughout.
- Read 16 words from full -> dout sequence is 0x01..0x10, empty=1 after the last read, and almost_empty=1 at count<=1.
- Hold wr & rd for 50 cycles while full with incrementing din -> count stays 16 and the output order is strictly FIFO, with no loss or duplication.
- wr & rd while empty with din=0xA5 -> count=1 and dout=0xA5 next cycle. With SRLQ_ERRFLAG_EN defined, underflow=1.
- Extra write while full, then rd alone while empty -> contents and count are unchanged. With the macro defined, overflow=1 and underflow=1, both sticky until rst; without it, both read 0.
- Assert rst at count=9 during a write -> next cycle count=0, empty=1 and flags are cleared. The next write at 0x3C reads back as 0x3C.
